// File: rtl/am2910_pkg.sv
// Shared types and sizes for the Am2910 microprogram sequencer.
// Opcode values match the instruction field I[3:0].
package am2910_pkg;

    localparam int AW    = 12;
    localparam int DEPTH = 5;
    localparam int SPW   = 3;

    typedef logic [AW-1:0] addr_t;

    typedef enum logic [3:0] {
        JZ   = 4'd0,
        CJS  = 4'd1,
        JMAP = 4'd2,
        CJP  = 4'd3,
        PUSH = 4'd4,
        JSRP = 4'd5,
        CJV  = 4'd6,
        JRP  = 4'd7,
        RFCT = 4'd8,
        RPCT = 4'd9,
        CRTN = 4'd10,
        CJPP = 4'd11,
        LDCT = 4'd12,
        LOOP = 4'd13,
        CONT = 4'd14,
        TWB  = 4'd15
    } opcode_e;

endpackage

// File: rtl/am2910_stack.sv
// Five-entry return-address LIFO with clear, saturating push and guarded pop.
// Only the pointer is reset; entry contents are don't-care until written.
module am2910_stack
    import am2910_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  push,
    input  logic  pop,
    input  logic  clear,
    input  addr_t push_data,
    output addr_t top,
    output logic  full
);

    addr_t          mem_q [DEPTH];
    logic [SPW-1:0] sp_q;
    logic [SPW-1:0] sp_d;
    logic [SPW-1:0] wr_idx;

    assign full = (sp_q == SPW'(DEPTH));

    always_comb begin
        sp_d   = sp_q;
        // A push onto a full stack replaces the top entry instead of growing.
        wr_idx = full ? SPW'(DEPTH - 1) : sp_q;
        if (clear) begin
            sp_d = '0;
        end else if (push) begin
            sp_d = full ? sp_q : sp_q + 3'd1;
        end else if (pop) begin
            sp_d = (sp_q == '0) ? sp_q : sp_q - 3'd1;
        end
    end

    always_comb begin
        top = '0;
        if (sp_q != '0) begin
            top = mem_q[sp_q - 3'd1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp_q <= '0;
        end else begin
            sp_q <= sp_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem_q[wr_idx] <= push_data;
        end
    end

endmodule

// File: rtl/am2910.sv
// Am2910 microprogram sequencer: next-address mux, microPC, loop counter R
// and return stack. Y is combinational from the instruction and current state.
module am2910
    import am2910_pkg::*;
(
    input  logic        clk,
    input  logic        nRESET,
    input  logic [3:0]  I,
    input  logic [11:0] D,
    output logic [11:0] Y,
    input  logic        nOE,
    input  logic        nCC,
    input  logic        nCCEN,
    input  logic        CI,
    input  logic        nRLD,
    output logic        nFULL,
    output logic        nPL,
    output logic        nMAP,
    output logic        nVECT
);

    opcode_e op;
    addr_t   upc_q, upc_d;
    addr_t   r_q, r_d;
    addr_t   y_int;
    addr_t   stk_top;
    logic    pass, r_zero;
    logic    push, pop, clear, r_load, r_dec;
    logic    stk_full;

    assign op     = opcode_e'(I);
    assign pass   = nCCEN | ~nCC;
    assign r_zero = (r_q == '0);

    always_comb begin
        y_int  = upc_q;
        push   = 1'b0;
        pop    = 1'b0;
        clear  = 1'b0;
        r_load = 1'b0;
        r_dec  = 1'b0;
        case (op)
            JZ:   begin y_int = '0; clear = 1'b1; end
            CJS:  if (pass) begin y_int = D; push = 1'b1; end
            JMAP: y_int = D;
            CJP:  if (pass) y_int = D;
            PUSH: begin push = 1'b1; r_load = pass; end
            JSRP: begin push = 1'b1; y_int = pass ? D : r_q; end
            CJV:  if (pass) y_int = D;
            JRP:  y_int = pass ? D : r_q;
            RFCT: if (!r_zero) begin y_int = stk_top; r_dec = 1'b1; end
                  else pop = 1'b1;
            RPCT: if (!r_zero) begin y_int = D; r_dec = 1'b1; end
            CRTN: if (pass) begin y_int = stk_top; pop = 1'b1; end
            CJPP: if (pass) begin y_int = D; pop = 1'b1; end
            LDCT: r_load = 1'b1;
            LOOP: if (pass) pop = 1'b1;
                  else y_int = stk_top;
            CONT: y_int = upc_q;
            TWB:  if (pass) pop = 1'b1;
                  else if (!r_zero) begin y_int = stk_top; r_dec = 1'b1; end
                  else begin y_int = D; pop = 1'b1; end
        endcase
    end

    // External R load wins over both the opcode load and the decrement.
    always_comb begin
        r_d = r_q;
        if (!nRLD || r_load) begin
            r_d = D;
        end else if (r_dec && !r_zero) begin
            r_d = r_q - 12'd1;
        end
        upc_d = y_int + {{(AW-1){1'b0}}, CI};
    end

    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            upc_q <= '0;
            r_q   <= '0;
        end else begin
            upc_q <= upc_d;
            r_q   <= r_d;
        end
    end

    am2910_stack u_stack (
        .clk       (clk),
        .rst_n     (nRESET),
        .push      (push),
        .pop       (pop),
        .clear     (clear),
        .push_data (upc_q),
        .top       (stk_top),
        .full      (stk_full)
    );

    assign Y     = nOE ? 'z : y_int;
    assign nFULL = ~stk_full;
    assign nMAP  = (op != JMAP);
    assign nVECT = (op != CJV);
    assign nPL   = (op == JMAP) || (op == CJV);

endmodule
